// File: rtl/tx_arbiter_pkg.sv
// uartUtil: shared arbiter state type and UART timing constants.
package uartUtil;
  typedef enum logic {ARB_IDLE, ARB_WAIT} arbState_t;
  localparam int FRAME_CYCLES = 10;
  localparam int DEFAULT_WATCHDOG_LIMIT = 12;
endpackage

// File: rtl/tx_rr_pick.sv
// tx_rr_pick: chooses which requester may hand over its next byte.
module tx_rr_pick #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic v0,
  input  logic v1,
  input  logic lock_valid,
  input  logic lock_id,
  input  logic last_served,
  output logic gnt_valid,
  output logic gnt_id
);
  // A locked requester keeps the grant even while its valid is low.
  always_comb begin
    gnt_valid = lock_valid | v0 | v1;
    gnt_id = lock_valid ? lock_id : (v0 & v1) ? ((FIXED_PRIORITY != 0) ? 1'b0 : ~last_served) : (v1 & ~v0);
  end
endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: merges two byte streams onto one UART transmitter with a
// one-entry pending stage, message locking and a launch-to-done watchdog.
module tx_arbiter import uartUtil::*; #(
  parameter int FIXED_PRIORITY = 0,
  parameter int WATCHDOG_LIMIT = DEFAULT_WATCHDOG_LIMIT
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       req0Valid,
  input  logic       req1Valid,
  input  logic [7:0] req0Byte,
  input  logic [7:0] req1Byte,
  input  logic       req0Last,
  input  logic       req1Last,
  output logic       req0Ready,
  output logic       req1Ready,
  output logic       send,
  output logic [7:0] byteToLoad,
  input  logic       done,
  output logic       grantId,
  output logic       busy,
  output logic       txTimeout
);
  localparam int WDW = $clog2(WATCHDOG_LIMIT + 1);
  arbState_t state, state_nxt;
  logic pend_valid, pend_id, lock_valid, lock_id, last_served;
  logic [7:0] pend_byte, acc_byte;
  logic [WDW-1:0] wd;
  logic gnt_valid, gnt_id, accept, acc_last, fire;
  tx_rr_pick #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_pick (
    .v0(req0Valid),
    .v1(req1Valid),
    .lock_valid(lock_valid),
    .lock_id(lock_id),
    .last_served(last_served),
    .gnt_valid(gnt_valid),
    .gnt_id(gnt_id)
  );
  // Ready is gated by rstN so nothing is offered while the block is held in reset.
  always_comb begin
    req0Ready = rstN & gnt_valid & ~pend_valid & ~gnt_id;
    req1Ready = rstN & gnt_valid & ~pend_valid & gnt_id;
    accept = gnt_id ? (req1Valid & req1Ready) : (req0Valid & req0Ready);
    acc_byte = gnt_id ? req1Byte : req0Byte;
    acc_last = gnt_id ? req1Last : req0Last;
    send = pend_valid & ((state == ARB_IDLE) | done);
    fire = (state == ARB_WAIT) & ~done & (wd == WDW'(WATCHDOG_LIMIT - 1));
    state_nxt = send ? ARB_WAIT : ((state == ARB_WAIT) & (done | fire)) ? ARB_IDLE : state;
    busy = (state != ARB_IDLE) | pend_valid;
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= ARB_IDLE;
      pend_valid <= 1'b0;
      pend_byte <= 8'h00;
      pend_id <= 1'b0;
      lock_valid <= 1'b0;
      lock_id <= 1'b0;
      last_served <= 1'b1;
      wd <= '0;
      byteToLoad <= 8'h00;
      grantId <= 1'b0;
      txTimeout <= 1'b0;
    end else begin
      state <= state_nxt;
      txTimeout <= fire;
      if (accept) begin
        pend_valid <= 1'b1;
        pend_byte <= acc_byte;
        pend_id <= gnt_id;
        last_served <= gnt_id;
        lock_valid <= ~acc_last;
        lock_id <= gnt_id;
      end else if (send) begin
        pend_valid <= 1'b0;
      end
      if (send) begin
        byteToLoad <= pend_byte;
        grantId <= pend_id;
        wd <= '0;
      end else if ((state == ARB_WAIT) & ~done) begin
        wd <= wd + 1'b1;
      end
    end
  end
endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter FIXED_PRIORITY, default 0, meaning 0 = round-robin between requesters, 1 = requester 0 always wins.
REQ-002 Parameter WATCHDOG_LIMIT, default 12, meaning launch-to-done cycle count after which a frame is abandoned.
REQ-003 Port clk  input  1  single clock; the baud clock that also drives the transmitter.
REQ-004 Port rstN  input  1  reset, asynchronous, active-low.
REQ-005 Port req0Valid / req1Valid  input  1 each  requester has a byte offered.
REQ-006 Port req0Byte / req1Byte  input  8 each  offered byte.
REQ-007 Port req0Last / req1Last  input  1 each  offered byte ends that requester's message.
REQ-008 Port req0Ready / req1Ready  output  1 each  byte accepted this cycle when Valid and Ready are both high.
REQ-009 Port send  output  1  launch request to the transmitter.
REQ-010 Port byteToLoad  output  8  byte to the transmitter; held stable for the whole frame.
REQ-011 Port done  input  1  transmitter stop-bit indication, high for exactly one cycle per frame.
REQ-012 Port grantId  output  1  requester that owns the byte currently on byteToLoad.
REQ-013 Port busy  output  1  high whenever state is not ARB_IDLE or the pending register is full.
REQ-014 Port txTimeout  output  1  one-cycle pulse when the watchdog fires.

Function
REQ-015 Storage SHALL be a one-entry pending register (pendValid, pendByte, pendLast, pendId) plus a current register (byteToLoad, grantId).
REQ-016 Ready SHALL be high only for the granted requester, only while pendValid=0, and never for both requesters in the same cycle.
REQ-017 Arbitration with no lock SHALL work as follows: one valid wins; if both are valid, FIXED_PRIORITY=0 picks the requester not served last and FIXED_PRIORITY=1 picks requester 0.
REQ-018 Accepting a byte with Last=0 SHALL set lock to that requester; only it is then granted until a byte with Last=1 is accepted.
REQ-019 The FSM SHALL have two states, ARB_IDLE and ARB_WAIT.
REQ-020 In ARB_IDLE: send = pendValid; when pendValid=1, the next edge SHALL load current from pending, clear pendValid, reset the watchdog and enter ARB_WAIT.
REQ-021 In ARB_WAIT with done=0: send SHALL be 0 and the watchdog SHALL increment.
REQ-022 In ARB_WAIT with done=1 and pendValid=1: send SHALL be 1 combinationally in that same cycle; the edge SHALL load current from pending, clear pendValid and reset the watchdog (back-to-back frames, no idle bit).
REQ-023 In ARB_WAIT with done=1 and pendValid=0: send SHALL be 0 and the next state SHALL be ARB_IDLE.
REQ-024 If the watchdog reaches WATCHDOG_LIMIT without done, the block SHALL pulse txTimeout, enter ARB_IDLE and keep pendValid and lock unchanged.
REQ-025 A requester accept and a pending-to-current transfer in the same cycle SHALL be excluded, because Ready requires pendValid=0.
REQ-026 byteToLoad and grantId SHALL change only on a launch edge.
REQ-027 Valid dropping without a handshake SHALL be legal and SHALL not alter lock.

Reset
REQ-028 When rstN=0, the block SHALL asynchronously set state=ARB_IDLE, pendValid=0, lock cleared, last-served=1, watchdog=0, byteToLoad=8'h00 and grantId=0.
REQ-029 During reset the outputs SHALL be send=0, Ready=0, busy=0 and txTimeout=0.
REQ-030 A reset asserted mid-frame SHALL discard all bytes; the transmitter is reset by the same system reset.

Structure
REQ-031 Package uartUtil SHALL hold the arbState_t enum (ARB_IDLE, ARB_WAIT), FRAME_CYCLES=10 and the WATCHDOG_LIMIT default.
REQ-032 One combinational sub-module, tx_rr_pick, SHALL compute the grant from valids, lock, last-served and FIXED_PRIORITY.
REQ-033 Everything else SHALL be flat in tx_arbiter.

Verification
REQ-034 Single byte: req0 sends 8'hA5 with Last=1 while idle -> send high 1 cycle, byteToLoad=A5 and grantId=0 held until done, then ARB_IDLE.
REQ-035 Contention: both requesters continuously valid (bytes 11 and 22, Last=1) -> bytes alternate 11,22,11,22 on the line with no idle bit between frames.
REQ-036 Message lock: req1 sends 33(L=0),44(L=0),55(L=1) while req0 is valid -> 33,44,55 are transmitted before any req0 byte.
REQ-037 Priority: FIXED_PRIORITY=1 with both valid -> every frame carries req0's byte.
REQ-038 Watchdog: done tied low after a launch -> txTimeout pulses 12 cycles after the launch edge, state returns to ARB_IDLE and the pending byte launches next.
REQ-039 Reset mid-frame: rstN low during the 5th data bit -> send=0, pendValid=0 and byteToLoad=00 immediately, with no clock edge required.
